eh2_exu_flush_arb: RTL and testbench
====================================

// Module: eh2_exu_flush_arb
// PURPOSE
//  Downstream of the two per-pipe ALU control stages. Merges their per-thread flush_upper/flush_path into one
//  registered flush per thread, oldest-pipe (i0) wins. Enqueues resolved branch outcomes into a small
//  ready/valid queue that drains to the branch-predictor update port.
// PARAMETERS
//  NUM_THREADS  2  hardware threads
//  BPQ_DEPTH    4  BP-update queue entries (power of 2, >=2)
// PORTS
//  clk               in   1         core clock
//  rst               in   1         reset; decided: one clock, reset asynchronous and active-high
//  dec_tlu_flush     in   NT        lower (commit) flush per thread, highest priority
//  i0_flush_upper    in   NT        pipe-0 ALU upper flush per thread
//  i0_flush_path     in   31        pipe-0 redirect PC [31:1]
//  i0_br_valid       in   1         pipe-0 resolved a branch/jump this cycle
//  i0_tid            in   1         pipe-0 thread id
//  i0_pc             in   31        pipe-0 branch PC [31:1]
//  i0_pkt            in   pkt       pipe-0 {misp, ataken, hist[1:0]} from predict_p_ff
//  i1_*              in   as i0_*   pipe-1 (younger) equivalents
//  exu_flush_final   out  NT        registered upper flush, one-cycle pulse
//  exu_flush_path    out  NT*31     registered redirect PC per thread
//  bpu_upd_valid     out  1         queue head valid
//  bpu_upd_ready     in   1         BP accepts head this cycle
//  bpu_upd_pkt       out  pkt       head entry {tid, pc, misp, ataken, hist}
//  bpq_drop_cnt      out  8         saturating count of dropped enqueues
// BEHAVIOUR
//  Reset: exu_flush_final=0, exu_flush_path=0, queue empty (bpu_upd_valid=0), bpq_drop_cnt=0, shadow=0.
//  Flush select, per thread t, same cycle:
//   - raw0 = i0_flush_upper[t]; raw1 = i1_flush_upper[t] & ~raw0 (younger killed by older).
//   - blocked if dec_tlu_flush[t] or shadow[t]; else hit = raw0|raw1, path = raw0 ? i0 : i1.
//  Latency 1: exu_flush_final[t] <= hit; exu_flush_path[t] <= path when hit, else held.
//  shadow[t] <= hit: suppresses any upper flush on t the cycle after a flush issues (wrong-path shadow).
//  dec_tlu_flush[t] also clears a pending exu_flush_final[t] next cycle (commit flush overrides).
//  BP queue enqueue, cycle order i0 then i1:
//   - e0 = i0_br_valid & ~dec_tlu_flush[i0_tid] & ~shadow[i0_tid].
//   - e1 = i1_br_valid & ~dec_tlu_flush[i1_tid] & ~shadow[i1_tid]
//          & ~(i0_tid==i1_tid & i0_flush_upper[i0_tid]).
//   - Free slots = DEPTH - count + (bpu_upd_valid & bpu_upd_ready); dequeue frees same cycle.
//   - e0 enqueues first; e1 only if a second slot remains. Each refused enqueue increments
//     bpq_drop_cnt (sat 255); drop when 2 refused adds 2, saturating.
//  Dequeue: head popped on bpu_upd_valid & bpu_upd_ready; bpu_upd_pkt stable while valid & ~ready.
//  Pointers wrap mod BPQ_DEPTH; count has log2(DEPTH)+1 bits. Full and enqueue+dequeue allowed.
//  Queue is not purged by flushes: entries are resolved, architecturally useful history.
//  Reset mid-operation: all state asynchronously cleared, queue contents discarded.
// STRUCTURE
//  eh2_pkg: typedef eh2_bp_upd_pkt_t {tid, pc[31:1], misp, ataken, hist[1:0]}.
//  Sub-module eh2_exu_bpq: 2-write/1-read circular FIFO with free-slot count; arbitration stays on top.
// TESTING
//  1 i0/i1 both flush T0, paths 0x100/0x200 -> next cycle exu_flush_final=01, path[T0]=0x100.
//  2 i1 flush T1 path 0x80, dec_tlu_flush[1]=1 same cycle -> exu_flush_final[1]=0 next cycle.
//  3 Flush T0 cycle N, i0 flush T0 again cycle N+1 -> only one pulse (cycle N+1), path unchanged.
//  4 DEPTH=4, ready=0, 5 single enqueues -> count 4, drop_cnt=1, head = first pc.
//  5 Full queue, ready=1, e0+e1 same cycle -> 1 popped, i0 accepted, i1 dropped, drop_cnt+1.
//  6 Assert rst with 3 entries queued and flush pending -> all outputs 0 without a clock edge.

Source files
------------

// File: rtl/eh2_exu_flush_arb_pkg.sv
// Shared types for the EXU flush arbiter: BP-update packet layout and the predict packet from the ALU stages.
// Also holds thread/queue sizing and small packing/saturation helpers.
package eh2_exu_flush_arb_pkg;

    localparam int NUM_THREADS   = 2;
    localparam int TID_W         = 1;
    localparam int EH2_BPQ_DEPTH = 4;

    typedef struct packed {
        logic       misp;
        logic       ataken;
        logic [1:0] hist;
    } eh2_predict_pkt_t;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [31:1]      pc;
        logic             misp;
        logic             ataken;
        logic [1:0]       hist;
    } eh2_bp_upd_pkt_t;

    function automatic eh2_bp_upd_pkt_t mk_upd(logic [TID_W-1:0] tid, logic [31:1] pc,
                                               eh2_predict_pkt_t p);
        eh2_bp_upd_pkt_t r;
        r.tid    = tid;
        r.pc     = pc;
        r.misp   = p.misp;
        r.ataken = p.ataken;
        r.hist   = p.hist;
        return r;
    endfunction

    function automatic logic [7:0] sat_add8(logic [7:0] a, logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

endpackage

// File: rtl/eh2_exu_flush_arb_if.sv
// Bundle between the two ALU control stages, the flush consumers and the BP-update port.
// master drives pipe results and the BP ready; slave is the arbiter.
interface eh2_exu_flush_arb_if;
    import eh2_exu_flush_arb_pkg::*;

    logic [NUM_THREADS-1:0]        dec_tlu_flush;
    logic [NUM_THREADS-1:0]        i0_flush_upper;
    logic [31:1]                   i0_flush_path;
    logic                          i0_br_valid;
    logic [TID_W-1:0]              i0_tid;
    logic [31:1]                   i0_pc;
    eh2_predict_pkt_t              i0_pkt;
    logic [NUM_THREADS-1:0]        i1_flush_upper;
    logic [31:1]                   i1_flush_path;
    logic                          i1_br_valid;
    logic [TID_W-1:0]              i1_tid;
    logic [31:1]                   i1_pc;
    eh2_predict_pkt_t              i1_pkt;
    logic [NUM_THREADS-1:0]        exu_flush_final;
    logic [NUM_THREADS-1:0][31:1]  exu_flush_path;
    logic                          bpu_upd_valid;
    logic                          bpu_upd_ready;
    eh2_bp_upd_pkt_t               bpu_upd_pkt;
    logic [7:0]                    bpq_drop_cnt;

    modport master (
        output dec_tlu_flush, i0_flush_upper, i0_flush_path, i0_br_valid, i0_tid, i0_pc, i0_pkt,
               i1_flush_upper, i1_flush_path, i1_br_valid, i1_tid, i1_pc, i1_pkt, bpu_upd_ready,
        input  exu_flush_final, exu_flush_path, bpu_upd_valid, bpu_upd_pkt, bpq_drop_cnt
    );

    modport slave (
        input  dec_tlu_flush, i0_flush_upper, i0_flush_path, i0_br_valid, i0_tid, i0_pc, i0_pkt,
               i1_flush_upper, i1_flush_path, i1_br_valid, i1_tid, i1_pc, i1_pkt, bpu_upd_ready,
        output exu_flush_final, exu_flush_path, bpu_upd_valid, bpu_upd_pkt, bpq_drop_cnt
    );

endinterface

// File: rtl/eh2_exu_flush_arb_bpq.sv
// 2-write/1-read circular queue of BP updates; writes land at the next edge, head is combinational.
// Caller must never push more than free_cnt; free_cnt already credits a same-cycle pop.
module eh2_exu_bpq
    import eh2_exu_flush_arb_pkg::*;
#(
    parameter int DEPTH = EH2_BPQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [1:0]                 push_cnt,
    input  eh2_bp_upd_pkt_t            push_dat0,
    input  eh2_bp_upd_pkt_t            push_dat1,
    input  logic                       pop,
    output logic                       head_vld,
    output eh2_bp_upd_pkt_t            head_dat,
    output logic [$clog2(DEPTH):0]     free_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    eh2_bp_upd_pkt_t mem [DEPTH];
    logic [PW-1:0]   wp;
    logic [PW-1:0]   rp;
    logic [CW-1:0]   count;
    logic            pop_ok;

    assign head_vld = (count != '0);
    assign pop_ok   = pop & head_vld;
    assign head_dat = head_vld ? mem[rp] : '0;
    assign free_cnt = CW'(DEPTH) - count + CW'(pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push_cnt != 2'd0) mem[wp] <= push_dat0;
            if (push_cnt == 2'd2) mem[wp + PW'(1)] <= push_dat1;
            wp    <= wp + PW'(push_cnt);
            rp    <= rp + PW'(pop_ok);
            count <= count + CW'(push_cnt) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/eh2_exu_flush_arb.sv
// Merges pipe-0/pipe-1 upper flushes into one registered per-thread flush (1 cycle, i0 wins) and
// queues resolved branches for the BP; refused enqueues are counted, BP stalls via bpu_upd_ready.
module eh2_exu_flush_arb
    import eh2_exu_flush_arb_pkg::*;
#(
    parameter int BPQ_DEPTH = EH2_BPQ_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    eh2_exu_flush_arb_if.slave   bus
);
    localparam int CW = $clog2(BPQ_DEPTH) + 1;

    logic [NUM_THREADS-1:0]       shadow;
    logic [NUM_THREADS-1:0]       hit;
    logic [NUM_THREADS-1:0][31:1] path_sel;

    // i1 only matters when i0 is quiet, so raw0|raw1 reduces to the OR of both pipes.
    always_comb begin
        hit      = '0;
        path_sel = '0;
        for (int t = 0; t < NUM_THREADS; t++) begin
            hit[t]      = ~(bus.dec_tlu_flush[t] | shadow[t])
                        & (bus.i0_flush_upper[t] | bus.i1_flush_upper[t]);
            path_sel[t] = bus.i0_flush_upper[t] ? bus.i0_flush_path : bus.i1_flush_path;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.exu_flush_final <= '0;
            bus.exu_flush_path  <= '0;
            shadow              <= '0;
        end else begin
            bus.exu_flush_final <= hit;
            shadow              <= hit;
            for (int t = 0; t < NUM_THREADS; t++)
                if (hit[t]) bus.exu_flush_path[t] <= path_sel[t];
        end
    end

    logic            e0, e1, acc0, acc1, pop;
    logic [CW-1:0]   free_cnt;
    logic [1:0]      push_cnt, n_drop;
    eh2_bp_upd_pkt_t pkt0, pkt1, push_dat0;

    assign e0 = bus.i0_br_valid & ~bus.dec_tlu_flush[bus.i0_tid] & ~shadow[bus.i0_tid];
    // A same-thread i0 redirect makes the younger i1 branch wrong-path.
    assign e1 = bus.i1_br_valid & ~bus.dec_tlu_flush[bus.i1_tid] & ~shadow[bus.i1_tid]
              & ~((bus.i0_tid == bus.i1_tid) & bus.i0_flush_upper[bus.i0_tid]);

    assign pop       = bus.bpu_upd_valid & bus.bpu_upd_ready;
    assign acc0      = e0 & (free_cnt != '0);
    assign acc1      = e1 & (free_cnt > CW'(acc0));
    assign push_cnt  = {1'b0, acc0} + {1'b0, acc1};
    assign n_drop    = {1'b0, e0 & ~acc0} + {1'b0, e1 & ~acc1};
    assign pkt0      = mk_upd(bus.i0_tid, bus.i0_pc, bus.i0_pkt);
    assign pkt1      = mk_upd(bus.i1_tid, bus.i1_pc, bus.i1_pkt);
    assign push_dat0 = acc0 ? pkt0 : pkt1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.bpq_drop_cnt <= '0;
        else     bus.bpq_drop_cnt <= sat_add8(bus.bpq_drop_cnt, n_drop);
    end

    eh2_exu_bpq #(.DEPTH(BPQ_DEPTH)) u_bpq (
        .clk       (clk),
        .rst       (rst),
        .push_cnt  (push_cnt),
        .push_dat0 (push_dat0),
        .push_dat1 (pkt1),
        .pop       (pop),
        .head_vld  (bus.bpu_upd_valid),
        .head_dat  (bus.bpu_upd_pkt),
        .free_cnt  (free_cnt)
    );

endmodule

// File: tb/tb_eh2_exu_flush_arb.sv
// Scoreboard bench for eh2_exu_flush_arb: directed flush/queue scenarios then randomized traffic,
// checked against a queue-based reference model.
module tb_eh2_exu_flush_arb;
    import eh2_exu_flush_arb_pkg::*;

    localparam int NT    = NUM_THREADS;
    localparam int DEPTH = EH2_BPQ_DEPTH;

    typedef struct {
        int                   due;
        logic [NT-1:0]        fin;
        logic [NT-1:0][31:1]  path;
        logic                 vld;
        logic [7:0]           drop;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    eh2_exu_flush_arb_if bus();
    eh2_exu_flush_arb dut (.clk(clk), .rst(rst), .bus(bus));

    logic [NT-1:0]        m_shadow;
    logic [NT-1:0][31:1]  m_path;
    int                   m_drop;
    eh2_bp_upd_pkt_t      m_q[$];
    eh2_bp_upd_pkt_t      sb_q[$];
    exp_t                 exp_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    function automatic eh2_bp_upd_pkt_t ref_pkt(logic [TID_W-1:0] tid, logic [31:1] pc,
                                                eh2_predict_pkt_t p);
        return '{tid: tid, pc: pc, misp: p.misp, ataken: p.ataken, hist: p.hist};
    endfunction

    task automatic model_reset();
        m_shadow = '0;
        m_path   = '0;
        m_drop   = 0;
        m_q.delete();
        sb_q.delete();
        exp_q.delete();
    endtask

    // Reference model for the cycle whose inputs are currently driven.
    task automatic apply();
        logic [NT-1:0]   fin;
        int              drops;
        eh2_bp_upd_pkt_t cand[$];
        exp_t            e;
        fin   = '0;
        drops = 0;
        if (bus.bpu_upd_ready && m_q.size() > 0) void'(m_q.pop_front());
        for (int t = 0; t < NT; t++) begin
            if (!bus.dec_tlu_flush[t] && !m_shadow[t]) begin
                if (bus.i0_flush_upper[t]) begin
                    fin[t] = 1'b1; m_path[t] = bus.i0_flush_path;
                end else if (bus.i1_flush_upper[t]) begin
                    fin[t] = 1'b1; m_path[t] = bus.i1_flush_path;
                end
            end
        end
        if (bus.i0_br_valid && !bus.dec_tlu_flush[bus.i0_tid] && !m_shadow[bus.i0_tid])
            cand.push_back(ref_pkt(bus.i0_tid, bus.i0_pc, bus.i0_pkt));
        if (bus.i1_br_valid && !bus.dec_tlu_flush[bus.i1_tid] && !m_shadow[bus.i1_tid]
            && !(bus.i0_tid == bus.i1_tid && bus.i0_flush_upper[bus.i0_tid]))
            cand.push_back(ref_pkt(bus.i1_tid, bus.i1_pc, bus.i1_pkt));
        foreach (cand[k]) begin
            if (m_q.size() < DEPTH) begin
                m_q.push_back(cand[k]);
                sb_q.push_back(cand[k]);
            end else drops++;
        end
        m_drop   = (m_drop + drops > 255) ? 255 : m_drop + drops;
        m_shadow = fin;
        e.due  = cyc + 1;
        e.fin  = fin;
        e.path = m_path;
        e.vld  = (m_q.size() != 0);
        e.drop = 8'(m_drop);
        exp_q.push_back(e);
    endtask

    task automatic step();
        apply();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.dec_tlu_flush  = '0;
        bus.i0_flush_upper = '0;
        bus.i0_flush_path  = '0;
        bus.i0_br_valid    = 1'b0;
        bus.i0_tid         = '0;
        bus.i0_pc          = '0;
        bus.i0_pkt         = '0;
        bus.i1_flush_upper = '0;
        bus.i1_flush_path  = '0;
        bus.i1_br_valid    = 1'b0;
        bus.i1_tid         = '0;
        bus.i1_pc          = '0;
        bus.i1_pkt         = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fin"},   64'(bus.exu_flush_final), 64'd0);
        for (int t = 0; t < NT; t++)
            chk($sformatf("%s_path%0d", tag, t), 64'(bus.exu_flush_path[t]), 64'd0);
        chk({tag, "_vld"},   64'(bus.bpu_upd_valid), 64'd0);
        chk({tag, "_pkt"},   64'(bus.bpu_upd_pkt), 64'd0);
        chk({tag, "_drop"},  64'(bus.bpq_drop_cnt), 64'd0);
    endtask

    // Monitor: per-cycle registered outputs and each BP handshake against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("flush_final", 64'(bus.exu_flush_final), 64'(exp_q[0].fin));
                for (int t = 0; t < NT; t++)
                    chk($sformatf("flush_path_t%0d", t), 64'(bus.exu_flush_path[t]),
                        64'(exp_q[0].path[t]));
                chk("bpu_upd_valid", 64'(bus.bpu_upd_valid), 64'(exp_q[0].vld));
                chk("bpq_drop_cnt", 64'(bus.bpq_drop_cnt), 64'(exp_q[0].drop));
                void'(exp_q.pop_front());
            end
            if (bus.bpu_upd_valid && bus.bpu_upd_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL bpu_pop: got pkt %0h expected no entry", bus.bpu_upd_pkt);
                end else begin
                    chk("bpu_upd_pkt", 64'(bus.bpu_upd_pkt), 64'(sb_q[0]));
                    void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        int rdy_pct;
        rst = 1'b1;
        idle_inputs();
        bus.bpu_upd_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // 1: both pipes flush T0, i0 path wins
        bus.i0_flush_upper = 2'b01; bus.i0_flush_path = 31'h100;
        bus.i1_flush_upper = 2'b01; bus.i1_flush_path = 31'h200;
        step();
        idle_inputs(); step();

        // 2: commit flush on T1 overrides i1 upper flush
        bus.i1_flush_upper = 2'b10; bus.i1_flush_path = 31'h80; bus.dec_tlu_flush = 2'b10;
        step();
        idle_inputs(); step();

        // 3: back-to-back flush on T0, second one shadowed
        bus.i0_flush_upper = 2'b01; bus.i0_flush_path = 31'h300;
        step();
        bus.i0_flush_path = 31'h400;
        step();
        idle_inputs(); step();

        // 4: five single enqueues into a stalled queue
        bus.bpu_upd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            bus.i0_br_valid = 1'b1; bus.i0_pc = 31'(32'h1000 + k * 4);
            bus.i0_pkt = 4'(k);
            step();
        end
        idle_inputs(); step();

        // 5: full queue, pop plus two enqueues
        bus.bpu_upd_ready = 1'b1;
        bus.i0_br_valid = 1'b1; bus.i0_tid = 1'b0; bus.i0_pc = 31'h2000; bus.i0_pkt = 4'hA;
        bus.i1_br_valid = 1'b1; bus.i1_tid = 1'b1; bus.i1_pc = 31'h2004; bus.i1_pkt = 4'h5;
        step();
        idle_inputs(); step();
        bus.bpu_upd_ready = 1'b0;

        // 6: async reset with 3 queued entries and a flush pending
        bus.i0_flush_upper = 2'b10; bus.i0_flush_path = 31'h555;
        step();
        idle_inputs();
        chk("pre_reset_fin", 64'(bus.exu_flush_final), 64'd2);
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomized traffic with varying BP back-pressure
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) rdy_pct = $urandom_range(10, 100);
            bus.bpu_upd_ready  = ($urandom_range(0, 99) < rdy_pct);
            bus.dec_tlu_flush  = 2'($urandom) & 2'($urandom) & 2'($urandom);
            bus.i0_flush_upper = 2'($urandom) & 2'($urandom);
            bus.i1_flush_upper = 2'($urandom) & 2'($urandom);
            bus.i0_flush_path  = 31'($urandom);
            bus.i1_flush_path  = 31'($urandom);
            bus.i0_br_valid    = 1'($urandom);
            bus.i1_br_valid    = 1'($urandom);
            bus.i0_tid         = 1'($urandom);
            bus.i1_tid         = 1'($urandom);
            bus.i0_pc          = 31'($urandom);
            bus.i1_pc          = 31'($urandom);
            bus.i0_pkt         = 4'($urandom);
            bus.i1_pkt         = 4'($urandom);
            step();
        end

        idle_inputs();
        bus.bpu_upd_ready = 1'b1;
        repeat (DEPTH + 3) step();
        @(negedge clk);
        chk("drain_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("drain_valid", 64'(bus.bpu_upd_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
